// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready immediate extender.
// Define IMM_ROTATE_EN to enable the data-processing rotate for ImmSrc=00.
module imm_extend_pipe #(
    parameter int W = 32,
    parameter int BR_SHL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instruction,
    input  logic [1:0]   ImmSrc,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_ext_imm,
    output logic         out_imm_err
);
    logic         r_s1_valid;
    logic [23:0]  r_s1_field;
    logic [1:0]   r_s1_fmt;
    logic         r_s2_valid;
    logic [W-1:0] r_ext_imm;
    logic         r_imm_err;
    logic         w_s2_load;
    logic         w_accept;
    logic [23:0]  w_field;
    logic [31:0]  w_dp;
    logic [W-1:0] w_br;
    logic [W-1:0] w_res;
    logic         w_unused_bits;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !flush && (!r_s1_valid || w_s2_load);
    assign w_accept  = in_valid && in_ready;
    assign w_field   = ImmSrc == 2'b00 ? {16'h0, instruction[7:0]} :
                       ImmSrc == 2'b01 ? {12'h0, instruction[11:0]} :
                       ImmSrc == 2'b10 ? instruction[23:0] : 24'h0;

`ifdef IMM_ROTATE_EN
    logic [3:0] r_s1_rot;
    logic [5:0] w_amt;
    assign w_amt = {1'b0, r_s1_rot, 1'b0};
    // a shift by 32 yields zero, so amount 0 falls out of the OR correctly
    assign w_dp = ({24'h0, r_s1_field[7:0]} >> w_amt) | ({24'h0, r_s1_field[7:0]} << (6'd32 - w_amt));
    assign w_unused_bits = ^instruction[31:24];
    always_ff @(posedge clk)
        if (w_accept) r_s1_rot <= instruction[11:8];
`else
    assign w_dp = {24'h0, r_s1_field[7:0]};
    assign w_unused_bits = ^{instruction[31:24], instruction[11:8]};
`endif

    assign w_br  = {{(W-24){r_s1_field[23]}}, r_s1_field} << BR_SHL;
    assign w_res = r_s1_fmt == 2'b00 ? W'(w_dp) :
                   r_s1_fmt == 2'b01 ? W'(r_s1_field) :
                   r_s1_fmt == 2'b10 ? w_br : '0;

    always_ff @(posedge clk)
        if (w_accept) begin
            r_s1_field <= w_field;
            r_s1_fmt   <= ImmSrc;
        end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_ext_imm  <= '0;
            r_imm_err  <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_imm_err  <= 1'b0;
        end else begin
            if (w_accept) r_s1_valid <= 1'b1;
            else if (w_s2_load) r_s1_valid <= 1'b0;
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_ext_imm <= w_res;
                    r_imm_err <= r_s1_fmt == 2'b11;
                end
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_ext_imm = r_ext_imm;
    assign out_imm_err = r_imm_err;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench with directed cases and random traffic.
// Honours IMM_ROTATE_EN the same way the design does.
module tb_imm_extend_pipe;
    localparam int W = 32;
    localparam int BR_SHL = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  instruction = '0;
    logic [1:0]   ImmSrc = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_ext_imm;
    logic         out_imm_err;

    int checks = 0;
    int errors = 0;
    logic [W:0] q[$];
    logic       p_stall = 1'b0;
    logic [W:0] p_out;

    imm_extend_pipe #(.W(W), .BR_SHL(BR_SHL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .ImmSrc(ImmSrc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ext_imm(out_ext_imm), .out_imm_err(out_imm_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [31:0] ins, input logic [1:0] src);
        logic [31:0] v;
        int s;
        case (src)
            2'b00: begin
                v = {24'h0, ins[7:0]};
`ifdef IMM_ROTATE_EN
                for (int i = 0; i < 2 * ins[11:8]; i++) v = {v[0], v[31:1]};
`endif
                return {1'b0, v};
            end
            2'b01: return {1'b0, 20'h0, ins[11:0]};
            2'b10: begin
                s = ins[23] ? int'(ins[23:0]) - (1 << 24) : int'(ins[23:0]);
                s = s * (1 << BR_SHL);
                return {1'b0, 32'(s)};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] src, input logic [31:0] ins);
        in_valid = 1'b1;
        ImmSrc = src;
        instruction = ins;
    endtask

    // Scoreboard monitor: push on input transfer, pop and compare on output handshake.
    always @(negedge clk) begin
        if (p_stall) chk("hold", {out_valid, out_imm_err, out_ext_imm}, {1'b1, p_out});
        if (reset || flush) begin
            q.delete();
            p_stall <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_output", {out_imm_err, out_ext_imm}, 64'hDEAD);
                else chk("scoreboard", {out_imm_err, out_ext_imm}, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(instruction, ImmSrc));
            p_stall <= out_valid && !out_ready;
            p_out <= {out_imm_err, out_ext_imm};
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp029;
        int budget;
`ifdef IMM_ROTATE_EN
        exp029 = 32'hFF000000;
`else
        exp029 = 32'h000000FF;
`endif
        cyc(); cyc(); cyc();
        @(negedge clk);
        chk("reset_state", {out_valid, out_imm_err, out_ext_imm}, 0);
        reset = 1'b0;
        cyc();
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);

        // rotate case with exact 2-cycle latency
        send(2'b00, 32'hA5A5_54FF);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_not_early", out_valid, 0);
        cyc();
        @(negedge clk);
        chk("dp_valid", out_valid, 1);
        chk("dp_value", {out_imm_err, out_ext_imm}, {1'b0, exp029});

        // branch sign extension with shift
        cyc();
        send(2'b10, 32'h1280_0001);
        cyc();
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("br_value", {out_valid, out_imm_err, out_ext_imm}, {2'b10, 32'hFE000004});

        // illegal format
        cyc();
        send(2'b11, 32'hFFFF_FFFF);
        cyc();
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("illegal", {out_valid, out_imm_err, out_ext_imm}, {2'b11, 32'h0});

        // back-to-back under stall
        cyc();
        out_ready = 1'b0;
        send(2'b01, 32'hFFFF_F123);
        cyc();
        send(2'b01, 32'h0000_0ABC);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("stall_head", {out_valid, out_ext_imm}, {1'b1, 32'h123});
        cyc(); cyc();
        @(negedge clk);
        chk("stall_hold", out_ext_imm, 32'h123);
        out_ready = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("drained_two", {out_valid, 32'(q.size())}, 0);

        // flush with both stages full and an offered input
        out_ready = 1'b0;
        send(2'b01, 32'h111);
        cyc();
        send(2'b01, 32'h222);
        cyc();
        send(2'b01, 32'h333);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_blocks_input", in_ready, 0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_clears_s2", out_valid, 0);
        cyc();
        @(negedge clk);
        chk("flush_clears_s1", out_valid, 0);
        send(2'b01, 32'h444);
        cyc();
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("after_flush", {out_valid, out_ext_imm}, {1'b1, 32'h444});

        // reset mid-stall with both stages full
        cyc();
        out_ready = 1'b0;
        send(2'b11, 32'h0);
        cyc();
        send(2'b01, 32'h555);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_err", {out_valid, out_imm_err}, 2'b11);
        reset = 1'b1;
        cyc();
        @(negedge clk);
        chk("reset_mid_stall", {out_valid, out_imm_err, out_ext_imm}, 0);
        reset = 1'b0;
        cyc();
        @(negedge clk);
        chk("ready_after_reset2", {in_ready, out_valid}, 2'b10);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc();
            in_valid = $urandom_range(0, 3) != 0;
            ImmSrc = 2'($urandom_range(0, 3));
            instruction = $urandom;
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 40) == 0;
        end
        cyc();
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while ((q.size() != 0 || out_valid) && budget < 20) begin
            cyc();
            budget++;
        end
        @(negedge clk);
        chk("final_drain", {out_valid, 32'(q.size())}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter W, default 32: output immediate width, legal values >= 32.
REQ-002 SHALL have parameter BR_SHL, default 0: left shift applied to branch immediates, legal values 0 or 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: instruction/ImmSrc pair offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts the pair this cycle.
REQ-007 SHALL have port instruction, input, 32 bits: raw instruction word.
REQ-008 SHALL have port ImmSrc, input, 2 bits: immediate format select.
REQ-009 SHALL have port flush, input, 1 bit: discard all in-flight entries.
REQ-010 SHALL have port out_valid, output, 1 bit: out_ext_imm holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-012 SHALL have port out_ext_imm, output, W bits: extended immediate.
REQ-013 SHALL have port out_imm_err, output, 1 bit: result came from an illegal ImmSrc; qualified by out_valid.

Function
REQ-014 SHALL form a two-stage pipeline: S1 registers the selected field, the format and the rotate amount; S2 registers the final value.
REQ-015 SHALL make a transfer occur when in_valid and in_ready are both high, and an output handshake when out_valid and out_ready are both high.
REQ-016 SHALL raise out_valid 2 cycles after an accepted input when the pipeline is not stalled.
REQ-017 SHALL let S2 load when S2 is empty or out_ready=1; SHALL let S1 advance into S2 only under that condition.
REQ-018 SHALL drive in_ready = !flush && (S1 empty || S1 advances this cycle), giving full throughput of 1 result per cycle with no bubble.
REQ-019 SHALL keep out_ext_imm and out_imm_err stable while out_valid=1 and out_ready=0.
REQ-020 SHALL encode ImmSrc=00 as a data-processing immediate: zero-extend instruction[7:0], rotated right within the low 32 bits by 2*instruction[11:8] (see REQ-028), with upper W-32 bits 0.
REQ-021 SHALL encode ImmSrc=01 as zero-extending instruction[11:0] to W.
REQ-022 SHALL encode ImmSrc=10 as sign-extending instruction[23:0] to W, then shifting left by BR_SHL with the sign preserved in bit W-1.
REQ-023 SHALL treat ImmSrc=11 as illegal: result 0 with out_imm_err=1.
REQ-024 SHALL make flush=1 clear both S1 and S2 valid bits at the next edge, with flush taking priority over any same-cycle accept or output handshake.
REQ-025 SHALL leave datapath registers unchanged on flush; only the valid bits and out_imm_err clear.

Reset
REQ-026 SHALL, while reset=1 at a rising edge, clear S1/S2 valid bits, out_ext_imm, and out_imm_err to 0.
REQ-027 SHALL give reset priority over flush and over any handshake; in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL use macro IMM_ROTATE_EN: when defined, ImmSrc=00 applies the rotate in REQ-020; when undefined, ImmSrc=00 yields {zeros, instruction[7:0]}, rotate hardware is removed and instruction[11:8] is ignored.

Verification
REQ-029 SHALL cover: IMM_ROTATE_EN defined, ImmSrc=00, instruction[11:0]=0x4FF, out_ready=1 -> 2 cycles later out_valid=1, out_ext_imm=0xFF000000; with the macro undefined -> 0x000000FF.
REQ-030 SHALL cover: W=32, BR_SHL=2, ImmSrc=10, instruction[23:0]=0x800001 -> out_ext_imm=0xFE000004, out_imm_err=0.
REQ-031 SHALL cover: back-to-back inputs of 0x123 and 0xABC with ImmSrc=01, out_ready=0 for 3 cycles -> in_ready=0 once both stages are full, output holds 0x123, then 0x123 and 0xABC emerge in order with none lost or duplicated.
REQ-032 SHALL cover: ImmSrc=11 -> out_valid=1, out_ext_imm=0, out_imm_err=1.
REQ-033 SHALL cover: flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0, the input is not accepted, and the next accepted input appears normally.
REQ-034 SHALL cover: reset asserted mid-stall with both stages full -> next cycle out_valid=0, out_ext_imm=0, in_ready=1 after reset deasserts.
